// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP sequencer.
package xadc_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE   = 3'd0,
    ST_CFG_WR   = 3'd1,
    ST_CFG_WAIT = 3'd2,
    ST_IDLE     = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_RD_WAIT  = 3'd5
  } state_t;

  // Averaging field encodings as presented on the switches.
  typedef enum logic [1:0] {
    AVG_NONE = 2'd0,
    AVG_16   = 2'd1,
    AVG_64   = 2'd2,
    AVG_256  = 2'd3
  } avg_t;

  localparam logic [6:0] CFG_ADDR = 7'h40;  // config reg 0
  localparam logic [6:0] RES_ADDR = 7'h03;  // VP/VN result
  localparam int         AVG_LSB  = 12;
  localparam int         AVG_MSB  = 13;

  // Config reg 0 image: base contents with the averaging field replaced.
  function automatic logic [15:0] cfg_word(input logic [15:0] base, input logic [1:0] avg);
    logic [15:0] w;
    w = base;
    w[AVG_MSB:AVG_LSB] = avg;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous levels (switches).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages; the first may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Owns the XADC DRP: writes the averaging config, then reads VP/VN after each eoc.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter logic [15:0] CFG_BASE     = 16'h0003,
  parameter int          SETTLE_CYC   = 16,
  parameter int          DRDY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  avg,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] do_i,
  input  logic        drdy,
  input  logic        eoc,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        cfg_done,
  output logic        err
);

  // Last counter value before leaving the state; the counter starts at 0 on entry.
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(DRDY_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  avg_s;
  logic [1:0]  avg_applied;
  logic [7:0]  cnt;
  logic        eoc_pend;
  logic        wait_st;
  logic        timeout;

  sync_2ff #(.WIDTH(2)) u_avg_sync (
    .clk (clk),
    .rst (rst),
    .d   (avg),
    .q   (avg_s)
  );

  assign wait_st = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT);
  // drdy on the final wait cycle still counts as a completed access.
  assign timeout = wait_st && !drdy && (cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_SETTLE;
    else     state <= state_nx;
  end

  // Next-state and DRP drive; outputs decode the current state so reset forces them to 0.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nx = state;
    den      = 1'b0;
    dwe      = 1'b0;
    daddr    = '0;
    di       = '0;
    unique case (state)
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) state_nx = ST_CFG_WR;
      end
      ST_CFG_WR: begin
        den      = 1'b1;
        dwe      = 1'b1;
        daddr    = CFG_ADDR;
        di       = cfg_word(CFG_BASE, avg_s);
        state_nx = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (drdy)         state_nx = ST_IDLE;
        else if (timeout) state_nx = ST_CFG_WR;
      end
      ST_IDLE: begin
        // A pending read beats a reconfiguration; the write follows on the next IDLE visit.
        if (eoc || eoc_pend)            state_nx = ST_RD_REQ;
        else if (avg_s != avg_applied)  state_nx = ST_CFG_WR;
      end
      ST_RD_REQ: begin
        den      = 1'b1;
        daddr    = RES_ADDR;
        state_nx = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drdy)         state_nx = ST_IDLE;
        else if (timeout) state_nx = ST_CFG_WR;
      end
      default: state_nx = ST_SETTLE;
    endcase
  end

  // Shared cycle counter for the settle delay and the drdy timeout; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || (state_nx != state))               cnt <= '0;
    else if ((state == ST_SETTLE) || wait_st)     cnt <= cnt + 8'd1;
  end

  // Remember which averaging value the XADC currently holds.
  always_ff @(posedge clk) begin
    if (rst)                     avg_applied <= '0;
    else if (state == ST_CFG_WR) avg_applied <= avg_s;
  end

  // Config-written flag: dropped when a write starts, raised when it completes.
  always_ff @(posedge clk) begin
    if (rst)                                  cfg_done <= 1'b0;
    else if (state == ST_CFG_WR)              cfg_done <= 1'b0;
    else if ((state == ST_CFG_WAIT) && drdy)  cfg_done <= 1'b1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end

  // Capture read data and strobe it for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if ((state == ST_RD_WAIT) && drdy) begin
        sample       <= do_i;
        sample_valid <= 1'b1;
      end
    end
  end

  // One-deep memory for an eoc that lands while a read is already in flight.
  always_ff @(posedge clk) begin
    if (rst)
      eoc_pend <= 1'b0;
    else if ((state == ST_IDLE) && (state_nx == ST_RD_REQ))
      eoc_pend <= 1'b0;
    else if (eoc && ((state == ST_RD_REQ) || (state == ST_RD_WAIT)))
      eoc_pend <= 1'b1;
  end

endmodule
